// File: rtl/shift_sequencer.sv
// Multi-cycle shifter/rotator: accepts one request, shifts by at most MAXSTEP
// bits per cycle, then presents the result until the consumer takes it.
module shift_sequencer #(
    parameter int WIDTH   = 8,
    parameter int MAXSTEP = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i,
    input  logic [4:0]       n,
    input  logic             lr,
    input  logic             ar,
    input  logic             rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [5:0] LP_W6    = 6'(WIDTH);
    localparam logic [5:0] LP_MASK6 = 6'(WIDTH - 1);
    localparam logic [5:0] LP_MAX6  = 6'(MAXSTEP);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt, w_shifted;
    logic [5:0]       r_rem, w_rem_nxt;
    logic [5:0]       w_n6, w_eff, w_step;
    logic             r_lr, r_rot, r_fill;
    logic             w_lr_nxt, w_rot_nxt, w_fill_nxt;

    // Effective amount and one per-cycle step, built from single-bit shifts.
    always_comb begin
        w_n6 = {1'b0, n};
        if (rot)
            w_eff = w_n6 & LP_MASK6;
        else if (w_n6 > LP_W6)
            w_eff = LP_W6;
        else
            w_eff = w_n6;

        w_step    = (r_rem > LP_MAX6) ? LP_MAX6 : r_rem;
        w_shifted = r_data;
        for (int unsigned k = 0; k < MAXSTEP; k++) begin
            if (6'(k) < w_step) begin
                if (r_lr)
                    w_shifted = {w_shifted[WIDTH-2:0], r_rot & w_shifted[WIDTH-1]};
                else
                    w_shifted = {(r_rot ? w_shifted[0] : r_fill), w_shifted[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_rem_nxt   = r_rem;
        w_lr_nxt    = r_lr;
        w_rot_nxt   = r_rot;
        w_fill_nxt  = r_fill;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_data_nxt  = i;
                    w_lr_nxt    = lr;
                    w_rot_nxt   = rot;
                    w_fill_nxt  = ar & ~lr & ~rot & i[WIDTH-1];
                    w_rem_nxt   = w_eff;
                    w_state_nxt = (w_eff == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_data_nxt = w_shifted;
                w_rem_nxt  = r_rem - w_step;
                if (r_rem == w_step)
                    w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_rem   <= '0;
            r_lr    <= 1'b0;
            r_rot   <= 1'b0;
            r_fill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_rem   <= w_rem_nxt;
            r_lr    <= w_lr_nxt;
            r_rot   <= w_rot_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign o         = r_data;

endmodule
